// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA raster timing generator.
//
// Counts pixel ticks into a horizontal/vertical raster position. From that
// position it decodes the sync pulses, the active-video flag, the pixel
// coordinates and a frame-start strobe. All counting is gated by i_en, which
// is a one-clk pixel tick from the enable generator. Every output is
// combinational decode of the two counters (plus i_en for o_frame_start), so
// the outputs describe the pixel presented in the current tick window.
//
// Optional build macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit free-running
// frame counter output (o_frame_cnt).
//
// Ports:
//   clk            system clock
//   i_rst          asynchronous active-high reset (raster -> (0,0))
//   i_en           pixel tick, one clk wide
//   o_hsync        horizontal sync, active low
//   o_vsync        vertical sync, active low
//   o_active       high inside the visible area
//   o_x / o_y      pixel column / row, 0 outside the visible area
//   o_frame_start  one-clk pulse on the tick presenting pixel (0,0)
//   o_frame_cnt    (VGA_SYNC_FRAME_CNT_EN only) frame counter, wraps 255->0
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic          o_frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
 ,output logic [7:0]    o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          line_end;
  logic          frame_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Raster position. The vertical counter only moves on the line-wrap tick,
  // so vsync naturally spans whole lines.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Output decode. Coordinates are forced to 0 in blanking so the colour
  // stage can index memory with them without extra masking.
  always_comb begin
    o_hsync       = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    o_vsync       = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    o_active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    o_x           = o_active ? h_cnt : '0;
    o_y           = o_active ? v_cnt : '0;
    o_frame_start = i_en && (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Advances on the same edge at which the raster wraps to (0,0).
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                 o_frame_cnt <= '0;
    else if (i_en && frame_end) o_frame_cnt <= o_frame_cnt + 8'd1;
  end
`else
  // frame_end is only consumed by the frame counter.
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Instance "a" uses 640x480@60 timing,
// instance "b" uses a tiny 8x6 raster so whole frames run quickly.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 2 units later, well away from either clock edge.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, hs_a, vs_a, act_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       rst_b, en_b, hs_b, vs_b, act_b, fs_b;
  logic [9:0] x_b, y_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fc_a, fc_b;
`endif

  int checks = 0;
  int errors = 0;

  vga_sync_gen u_a (
    .clk(clk), .i_rst(rst_a), .i_en(en_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_active(act_a),
    .o_x(x_a), .o_y(y_a), .o_frame_start(fs_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,.o_frame_cnt(fc_a)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .clk(clk), .i_rst(rst_b), .i_en(en_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_active(act_b),
    .o_x(x_b), .o_y(y_b), .o_frame_start(fs_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,.o_frame_cnt(fc_b)
`endif
  );

  task automatic reset_a();
    en_a = 1'b0; rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    en_b = 1'b0; rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
  endtask

  // Reset held, then asynchronous reset mid-line at (300,2).
  task automatic test_reset();
    en_a = 1'b0; rst_a = 1'b1;
    @(posedge clk); #3;
    checks++;
    if ({hs_a, vs_a, act_a, x_a, y_a, fs_a} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b",
               {hs_a, vs_a, act_a, x_a, y_a, fs_a}, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0});
    end
    en_a = 1'b1; #1;
    checks++;
    if (fs_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_frame_start: got %b expected 1", fs_a);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; en_a = 1'b1;
    repeat (1900) @(posedge clk);
    #1 en_a = 1'b0;
    #2;
    checks++;
    if ({act_a, x_a, y_a} !== {1'b1, 10'd300, 10'd2}) begin
      errors++;
      $display("FAIL reset_preload: got act=%b x=%0d y=%0d expected act=1 x=300 y=2",
               act_a, x_a, y_a);
    end
    rst_a = 1'b1; #1;
    checks++;
    if ({hs_a, vs_a, act_a, x_a, y_a, fs_a} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b",
               {hs_a, vs_a, act_a, x_a, y_a, fs_a}, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0});
    end
    rst_a = 1'b0; en_a = 1'b1;
    @(posedge clk); #1 en_a = 1'b0;
    #2;
    checks++;
    if ({x_a, y_a} !== {10'd1, 10'd0}) begin
      errors++;
      $display("FAIL reset_restart: got x=%0d y=%0d expected x=1 y=0", x_a, y_a);
    end
  endtask

  // i_en tied high for one full line.
  task automatic test_line_timing();
    int hs_low = 0, hs_first = -1, act_n = 0, x_err = 0;
    reset_a();
    en_a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      #2;
      if (!hs_a) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
      if (act_a) act_n++;
      if (x_a !== ((i < 640) ? 10'(i) : 10'd0) || y_a !== 10'd0) x_err++;
      @(posedge clk); #1;
    end
    en_a = 1'b0; #2;
    checks++;
    if (hs_low !== 96) begin
      errors++;
      $display("FAIL line_hsync_width: got %0d expected 96", hs_low);
    end
    checks++;
    if (hs_first !== 656) begin
      errors++;
      $display("FAIL line_hsync_start: got %0d expected 656", hs_first);
    end
    checks++;
    if (act_n !== 640) begin
      errors++;
      $display("FAIL line_active_count: got %0d expected 640", act_n);
    end
    checks++;
    if (x_err !== 0) begin
      errors++;
      $display("FAIL line_x_sequence: got %0d bad samples expected 0", x_err);
    end
    checks++;
    if ({act_a, x_a, y_a} !== {1'b1, 10'd0, 10'd1}) begin
      errors++;
      $display("FAIL line_wrap: got act=%b x=%0d y=%0d expected act=1 x=0 y=1",
               act_a, x_a, y_a);
    end
  endtask

  // i_en on odd clks only: each position is presented for 2 clks.
  task automatic test_enable_gating();
    int hs_low = 0, act_n = 0, x_err = 0, fs_n = 0, fs_at = -1;
    int h;
    reset_a();
    for (int k = 0; k < 1600; k++) begin
      en_a = (k % 2 == 1);
      #2;
      h = k / 2;
      if (!hs_a) hs_low++;
      if (act_a) act_n++;
      if (x_a !== ((h < 640) ? 10'(h) : 10'd0)) x_err++;
      if (fs_a) begin fs_n++; fs_at = k; end
      @(posedge clk); #1;
    end
    en_a = 1'b0; #2;
    checks++;
    if (hs_low !== 192) begin
      errors++;
      $display("FAIL gate_hsync_width: got %0d expected 192", hs_low);
    end
    checks++;
    if (act_n !== 1280) begin
      errors++;
      $display("FAIL gate_active_count: got %0d expected 1280", act_n);
    end
    checks++;
    if (x_err !== 0) begin
      errors++;
      $display("FAIL gate_x_hold: got %0d bad samples expected 0", x_err);
    end
    checks++;
    if (fs_n !== 1 || fs_at !== 1) begin
      errors++;
      $display("FAIL gate_frame_start: got %0d pulses at %0d expected 1 pulse at 1", fs_n, fs_at);
    end
    checks++;
    if ({x_a, y_a} !== {10'd0, 10'd1}) begin
      errors++;
      $display("FAIL gate_line_span: got x=%0d y=%0d expected x=0 y=1", x_a, y_a);
    end
  endtask

  // Small raster, full scoreboard over 3 frames with i_en tied high.
  task automatic test_small_frames();
    int act_f[3] = '{0, 0, 0};
    int fs_n = 0, fs_pos[3] = '{-1, -1, -1}, vs_low = 0, vs_first = -1, hs_low = 0, sb_err = 0;
    int eh, ev;
    logic e_act;
    reset_b();
    en_b = 1'b1;
    for (int t = 0; t < 144; t++) begin
      #2;
      eh = t % 8; ev = (t / 8) % 6;
      e_act = (eh < 4) && (ev < 3);
      if (act_b !== e_act || x_b !== (e_act ? 10'(eh) : 10'd0) ||
          y_b !== (e_act ? 10'(ev) : 10'd0) ||
          hs_b !== !(eh == 5 || eh == 6) || vs_b !== (ev != 4) ||
          fs_b !== (t % 48 == 0))
        sb_err++;
      if (act_b) act_f[t / 48]++;
      if (fs_b) begin
        if (fs_n < 3) fs_pos[fs_n] = t;
        fs_n++;
      end
      if (!vs_b) begin
        if (vs_first < 0) vs_first = t;
        vs_low++;
      end
      if (!hs_b) hs_low++;
      @(posedge clk); #1;
    end
    #2;
    checks++;
    if (sb_err !== 0) begin
      errors++;
      $display("FAIL small_scoreboard: got %0d bad ticks expected 0", sb_err);
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (act_f[f] !== 12) begin
        errors++;
        $display("FAIL small_active_f%0d: got %0d expected 12", f, act_f[f]);
      end
    end
    checks++;
    if (fs_n !== 3) begin
      errors++;
      $display("FAIL small_fs_count: got %0d expected 3", fs_n);
    end
    checks++;
    if (fs_pos[1] - fs_pos[0] !== 48 || fs_pos[2] - fs_pos[1] !== 48) begin
      errors++;
      $display("FAIL small_fs_spacing: got %0d,%0d,%0d expected 0,48,96",
               fs_pos[0], fs_pos[1], fs_pos[2]);
    end
    checks++;
    if (vs_low !== 24 || vs_first !== 32) begin
      errors++;
      $display("FAIL small_vsync: got %0d low from %0d expected 24 low from 32", vs_low, vs_first);
    end
    checks++;
    if (hs_low !== 36) begin
      errors++;
      $display("FAIL small_hsync: got %0d expected 36", hs_low);
    end
    checks++;
    if (fs_b !== 1'b1 || x_b !== 10'd0 || y_b !== 10'd0) begin
      errors++;
      $display("FAIL small_frame_wrap: got fs=%b x=%0d y=%0d expected fs=1 x=0 y=0",
               fs_b, x_b, y_b);
    end
    en_b = 1'b0;
  endtask

  // Small raster with gated i_en: frame start only on the enabled clk.
  task automatic test_frame_wrap_gated();
    int fs_n = 0, fs_a0 = -1, fs_a1 = -1;
    reset_b();
    for (int k = 0; k < 100; k++) begin
      en_b = (k % 2 == 1);
      #2;
      if (fs_b) begin
        if (fs_n == 0) fs_a0 = k; else fs_a1 = k;
        fs_n++;
      end
      @(posedge clk); #1;
    end
    en_b = 1'b0;
    checks++;
    if (fs_n !== 2 || fs_a0 !== 1 || fs_a1 !== 97) begin
      errors++;
      $display("FAIL gated_frame_start: got %0d pulses at %0d,%0d expected 2 at 1,97",
               fs_n, fs_a0, fs_a1);
    end
  endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
  task automatic test_frame_cnt();
    reset_a();
    reset_b();
    #2;
    checks++;
    if (fc_a !== 8'd0 || fc_b !== 8'd0) begin
      errors++;
      $display("FAIL fcnt_reset: got %0d,%0d expected 0,0", fc_a, fc_b);
    end
    en_b = 1'b1;
    repeat (255 * 48) @(posedge clk);
    #3;
    checks++;
    if (fc_b !== 8'd255) begin
      errors++;
      $display("FAIL fcnt_255: got %0d expected 255", fc_b);
    end
    repeat (48) @(posedge clk);
    #3;
    checks++;
    if (fc_b !== 8'd0) begin
      errors++;
      $display("FAIL fcnt_wrap: got %0d expected 0", fc_b);
    end
    repeat (4 * 48) @(posedge clk);
    #3;
    checks++;
    if (fc_b !== 8'd4) begin
      errors++;
      $display("FAIL fcnt_end: got %0d expected 4", fc_b);
    end
    en_b = 1'b0;
  endtask
`endif

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    test_reset();
    test_line_timing();
    test_enable_gating();
    test_small_frames();
    test_frame_wrap_gated();
`ifdef VGA_SYNC_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
